// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request, stock and payout handshake bundle for change_dispenser
interface change_dispenser_if;
  logic        start;
  logic [15:0] credit;
  logic [15:0] price;
  logic [7:0]  num_500;
  logic [7:0]  num_1000;
  logic [7:0]  num_2000;
  logic [7:0]  num_5000;
  logic        dispense_ack;
  logic [3:0]  dispense_type;
  logic        dispense_valid;
  logic        busy;
  logic        done;
  logic [3:0]  error;
  logic [15:0] remaining;

  modport master (
    output start, credit, price, num_500, num_1000, num_2000, num_5000, dispense_ack,
    input  dispense_type, dispense_valid, busy, done, error, remaining
  );

  modport slave (
    input  start, credit, price, num_500, num_1000, num_2000, num_5000, dispense_ack,
    output dispense_type, dispense_valid, busy, done, error, remaining
  );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy change payout sequencer with ack timeout
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SELECT,
    S_EMIT,
    S_FINISH
  } state_t;

  // The wait counter runs 0..ACK_TIMEOUT-1 while an item is offered.
  localparam int WCW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(ACK_TIMEOUT - 1);

  localparam logic [3:0] T_500  = 4'b0001;
  localparam logic [3:0] T_1000 = 4'b0010;
  localparam logic [3:0] T_2000 = 4'b0100;
  localparam logic [3:0] T_5000 = 4'b1000;

  localparam logic [3:0] E_NONE     = 4'b0000;
  localparam logic [3:0] E_CREDIT   = 4'b0001;
  localparam logic [3:0] E_UNIT     = 4'b0010;
  localparam logic [3:0] E_STOCK    = 4'b0100;
  localparam logic [3:0] E_TIMEOUT  = 4'b1000;

  state_t          state;
  logic [15:0]     credit_q;
  logic [15:0]     price_q;
  logic [7:0]      stk_500;
  logic [7:0]      stk_1000;
  logic [7:0]      stk_2000;
  logic [7:0]      stk_5000;
  logic [15:0]     cur_amt;
  logic [WCW-1:0]  wait_cnt;

  logic [3:0]      dispense_type_q;
  logic            dispense_valid_q;
  logic            busy_q;
  logic            done_q;
  logic [3:0]      error_q;
  logic [15:0]     remaining_q;

  logic [15:0]     diff;
  logic [15:0]     diff_mod;
  logic            pick_ok;
  logic [3:0]      pick_type;
  logic [15:0]     pick_amt;

  assign bus.dispense_type  = dispense_type_q;
  assign bus.dispense_valid = dispense_valid_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.error          = error_q;
  assign bus.remaining      = remaining_q;

  // Change owed is only meaningful when credit >= price; the subtraction cannot wrap then.
  assign diff     = credit_q - price_q;
  assign diff_mod = diff % 16'd500;

  // Greedy choice: largest denomination that fits the amount owed and is still in stock.
  always_comb begin
    pick_ok   = 1'b1;
    pick_type = 4'b0000;
    pick_amt  = 16'd0;
    if (remaining_q >= 16'd5000 && stk_5000 != 8'd0) begin
      pick_type = T_5000;
      pick_amt  = 16'd5000;
    end else if (remaining_q >= 16'd2000 && stk_2000 != 8'd0) begin
      pick_type = T_2000;
      pick_amt  = 16'd2000;
    end else if (remaining_q >= 16'd1000 && stk_1000 != 8'd0) begin
      pick_type = T_1000;
      pick_amt  = 16'd1000;
    end else if (remaining_q >= 16'd500 && stk_500 != 8'd0) begin
      pick_type = T_500;
      pick_amt  = 16'd500;
    end else begin
      pick_ok = 1'b0;
    end
  end

  // Transaction sequencer; every output is a register so the payout interface sees clean levels.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      credit_q         <= 16'd0;
      price_q          <= 16'd0;
      stk_500          <= 8'd0;
      stk_1000         <= 8'd0;
      stk_2000         <= 8'd0;
      stk_5000         <= 8'd0;
      cur_amt          <= 16'd0;
      wait_cnt         <= '0;
      dispense_type_q  <= 4'b0000;
      dispense_valid_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= E_NONE;
      remaining_q      <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            credit_q <= bus.credit;
            price_q  <= bus.price;
            stk_500  <= bus.num_500;
            stk_1000 <= bus.num_1000;
            stk_2000 <= bus.num_2000;
            stk_5000 <= bus.num_5000;
            error_q  <= E_NONE;
            busy_q   <= 1'b1;
            state    <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (credit_q < price_q) begin
            error_q     <= E_CREDIT;
            remaining_q <= 16'd0;
            done_q      <= 1'b1;
            state       <= S_FINISH;
          end else begin
            remaining_q <= diff;
            if (diff_mod != 16'd0) begin
              error_q <= E_UNIT;
              done_q  <= 1'b1;
              state   <= S_FINISH;
            end else begin
              state <= S_SELECT;
            end
          end
        end

        S_SELECT: begin
          if (remaining_q == 16'd0) begin
            error_q <= E_NONE;
            done_q  <= 1'b1;
            state   <= S_FINISH;
          end else if (pick_ok) begin
            dispense_valid_q <= 1'b1;
            dispense_type_q  <= pick_type;
            cur_amt          <= pick_amt;
            wait_cnt         <= '0;
            state            <= S_EMIT;
          end else begin
            error_q <= E_STOCK;
            done_q  <= 1'b1;
            state   <= S_FINISH;
          end
        end

        S_EMIT: begin
          if (bus.dispense_ack) begin
            remaining_q      <= remaining_q - cur_amt;
            dispense_valid_q <= 1'b0;
            dispense_type_q  <= 4'b0000;
            state            <= S_SELECT;
            // Picks only happen on non-zero stock, the guards just make underflow impossible.
            case (dispense_type_q)
              T_500:   if (stk_500  != 8'd0) stk_500  <= stk_500  - 8'd1;
              T_1000:  if (stk_1000 != 8'd0) stk_1000 <= stk_1000 - 8'd1;
              T_2000:  if (stk_2000 != 8'd0) stk_2000 <= stk_2000 - 8'd1;
              T_5000:  if (stk_5000 != 8'd0) stk_5000 <= stk_5000 - 8'd1;
              default: ;
            endcase
          end else if (wait_cnt == WAIT_LAST) begin
            error_q          <= E_TIMEOUT;
            dispense_valid_q <= 1'b0;
            dispense_type_q  <= 4'b0000;
            done_q           <= 1'b1;
            state            <= S_FINISH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_FINISH: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          dispense_valid_q <= 1'b0;
          dispense_type_q  <= 4'b0000;
          done_q           <= 1'b0;
          busy_q           <= 1'b0;
          state            <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  change_dispenser_if dif();

  change_dispenser #(.ACK_TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (dif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  item_q[$];
  logic [15:0] rem_q[$];
  int          done_cnt;
  int          valid_cyc;
  int          cyc;
  int          gap_err;
  int          type_err;
  logic [15:0] rem_first;
  logic [31:0] items_packed;
  logic        busy_after_start;
  int          bad_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One transaction from start to return-to-idle; records items, remaining after each ack, done pulses.
  task automatic run_txn(input logic [15:0] cr, input logic [15:0] pr,
                         input logic [7:0] n5, input logic [7:0] n10,
                         input logic [7:0] n20, input logic [7:0] n50,
                         input bit ack_on, input bit poke);
    bit acked;
    item_q.delete();
    rem_q.delete();
    done_cnt = 0; valid_cyc = 0; cyc = 0; gap_err = 0; type_err = 0;
    items_packed = 32'd0; rem_first = 16'd0;
    dif.credit = cr; dif.price = pr;
    dif.num_500 = n5; dif.num_1000 = n10; dif.num_2000 = n20; dif.num_5000 = n50;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    busy_after_start = dif.busy;
    while (dif.busy && cyc < 300) begin
      if (cyc == 1) rem_first = dif.remaining;
      if (dif.done) done_cnt++;
      if (dif.dispense_valid) valid_cyc++;
      if (!dif.dispense_valid && dif.dispense_type != 4'd0) type_err++;
      acked = ack_on && dif.dispense_valid;
      dif.dispense_ack = acked;
      dif.start = poke && (cyc == 1);
      if (poke && cyc == 1) begin
        dif.credit = 16'd0;
        dif.price  = 16'd100;
      end
      if (acked) begin
        item_q.push_back(dif.dispense_type);
        items_packed = {items_packed[27:0], dif.dispense_type};
      end
      tick();
      if (acked) begin
        rem_q.push_back(dif.remaining);
        if (dif.dispense_valid) gap_err++;
      end
      cyc++;
    end
    dif.dispense_ack = 1'b0;
    dif.start = 1'b0;
    check("txn_bounded", cyc < 300, 1);
    check("busy_after_start", busy_after_start, 1);
    check("done_idle_low", dif.done, 0);
  endtask

  initial begin
    dif.start = 1'b0; dif.credit = 16'd0; dif.price = 16'd0;
    dif.num_500 = 8'd0; dif.num_1000 = 8'd0; dif.num_2000 = 8'd0; dif.num_5000 = 8'd0;
    dif.dispense_ack = 1'b0;

    // asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #1;
    check("rst_valid", dif.dispense_valid, 0);
    check("rst_type", dif.dispense_type, 0);
    check("rst_busy", dif.busy, 0);
    check("rst_done", dif.done, 0);
    check("rst_error", dif.error, 0);
    check("rst_remaining", dif.remaining, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // 5000-1500: 2000, 1000, 500
    run_txn(16'd5000, 16'd1500, 8'd10, 8'd10, 8'd10, 8'd10, 1'b1, 1'b0);
    check("t1_items", items_packed, 32'h421);
    check("t1_nitems", item_q.size(), 3);
    check("t1_rem_first", rem_first, 16'd3500);
    if (rem_q.size() == 3) begin
      check("t1_rem0", rem_q[0], 16'd1500);
      check("t1_rem1", rem_q[1], 16'd500);
      check("t1_rem2", rem_q[2], 16'd0);
    end else begin
      check("t1_rem_size", rem_q.size(), 3);
    end
    check("t1_error", dif.error, 4'b0000);
    check("t1_done", done_cnt, 1);
    check("t1_cycles", cyc, 9);
    check("t1_gap", gap_err, 0);
    check("t1_type_idle", type_err, 0);
    check("t1_remaining", dif.remaining, 16'd0);

    // 4000 with no 2000 notes and one 1000 note
    run_txn(16'd5000, 16'd1000, 8'd10, 8'd1, 8'd0, 8'd10, 1'b1, 1'b0);
    check("t2_items", items_packed, 32'h2111111);
    check("t2_error", dif.error, 4'b0000);
    check("t2_done", done_cnt, 1);
    check("t2_cycles", cyc, 17);
    check("t2_gap", gap_err, 0);

    // insufficient credit
    run_txn(16'd1000, 16'd1500, 8'd10, 8'd10, 8'd10, 8'd10, 1'b1, 1'b0);
    check("t3_valid_cycles", valid_cyc, 0);
    check("t3_error", dif.error, 4'b0001);
    check("t3_remaining", dif.remaining, 16'd0);
    check("t3_cycles", cyc, 2);
    check("t3_done", done_cnt, 1);

    // change not a multiple of 500
    run_txn(16'd1200, 16'd500, 8'd10, 8'd10, 8'd10, 8'd10, 1'b1, 1'b0);
    check("t4_error", dif.error, 4'b0010);
    check("t4_remaining", dif.remaining, 16'd700);
    check("t4_valid_cycles", valid_cyc, 0);

    // out of 500 coins
    run_txn(16'd2000, 16'd1500, 8'd0, 8'd10, 8'd10, 8'd10, 1'b1, 1'b0);
    check("t5_items", item_q.size(), 0);
    check("t5_error", dif.error, 4'b0100);
    check("t5_remaining", dif.remaining, 16'd500);
    check("t5_cycles", cyc, 3);

    // ack never comes; start pulse while busy must be ignored
    run_txn(16'd2000, 16'd1500, 8'd10, 8'd10, 8'd10, 8'd10, 1'b0, 1'b1);
    check("t6_valid_cycles", valid_cyc, 4);
    check("t6_error", dif.error, 4'b1000);
    check("t6_remaining", dif.remaining, 16'd500);
    check("t6_done", done_cnt, 1);
    check("t6_cycles", cyc, 7);
    tick(); tick();
    check("t6_error_held", dif.error, 4'b1000);
    check("t6_idle", dif.busy, 0);

    // reset in the middle of the second item
    dif.credit = 16'd5000; dif.price = 16'd1500;
    dif.num_500 = 8'd10; dif.num_1000 = 8'd10; dif.num_2000 = 8'd10; dif.num_5000 = 8'd10;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    tick();
    tick();
    check("t7_first_valid", dif.dispense_valid, 1);
    dif.dispense_ack = 1'b1;
    tick();
    dif.dispense_ack = 1'b0;
    check("t7_rem_after_ack", dif.remaining, 16'd1500);
    tick();
    check("t7_second_valid", dif.dispense_valid, 1);
    check("t7_second_type", dif.dispense_type, 4'b0010);
    #2 reset = 1'b0;
    #1;
    check("t7_rst_valid", dif.dispense_valid, 0);
    check("t7_rst_type", dif.dispense_type, 0);
    check("t7_rst_busy", dif.busy, 0);
    check("t7_rst_done", dif.done, 0);
    check("t7_rst_error", dif.error, 0);
    check("t7_rst_remaining", dif.remaining, 0);
    bad_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dif.done || dif.dispense_valid || dif.busy) bad_cnt++;
    end
    check("t7_quiet_in_reset", bad_cnt, 0);
    reset = 1'b1;
    tick();
    run_txn(16'd5000, 16'd1000, 8'd10, 8'd1, 8'd0, 8'd10, 1'b1, 1'b0);
    check("t7_fresh_items", items_packed, 32'h2111111);
    check("t7_fresh_error", dif.error, 4'b0000);
    check("t7_fresh_done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, is the maximum number of cycles dispense_valid may wait for dispense_ack before abort.
REQ-002 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; reset==0 SHALL force the reset state immediately, independent of clock.
REQ-004 start  input  1  single-cycle request to return change; sampled only in IDLE.
REQ-005 credit  input  16  total inserted money in units of 1, sampled on accepted start.
REQ-006 price  input  16  selected product price, sampled on accepted start.
REQ-007 num_500, num_1000, num_2000, num_5000  input  8 each  coin/note stock, sampled on accepted start.
REQ-008 dispense_ack  input  1  payout mechanism accepts current item.
REQ-009 dispense_type  output  4  one-hot item being paid out: 0001=500, 0010=1000, 0100=2000, 1000=5000; 0000 when dispense_valid==0.
REQ-010 dispense_valid  output  1  dispense_type is valid and held until acknowledged.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on transaction end, success or error.
REQ-013 error  output  4  result code, held until the next accepted start.
REQ-014 remaining  output  16  change still owed, live.

Function
REQ-015 States SHALL be IDLE, CHECK, SELECT, EMIT, FINISH.
REQ-016 IDLE: start==1 SHALL latch the inputs, clear error, and move to CHECK; busy SHALL be high the next cycle.
REQ-017 start while busy SHALL be ignored, with no effect on state or outputs.
REQ-018 CHECK: credit<price SHALL set error=0001 and remaining=0, then go to FINISH.
REQ-019 CHECK otherwise: remaining SHALL be set to credit-price (16-bit, no overflow possible); if it is not a multiple of 500, error=0010, then go to FINISH; else go to SELECT.
REQ-020 SELECT with remaining==0 SHALL go to FINISH with error=0000.
REQ-021 SELECT otherwise SHALL pick the largest denomination d with d<=remaining and internal stock(d)>0, priority 5000>2000>1000>500.
REQ-022 SELECT: a pick SHALL go to EMIT; no pick SHALL set error=0100 with remaining unchanged, then go to FINISH.
REQ-023 EMIT: dispense_valid=1 and dispense_type=one-hot(d) SHALL hold stable until dispense_ack.
REQ-024 EMIT: the cycle with dispense_valid&dispense_ack SHALL subtract d from remaining, decrement internal stock(d), and go to SELECT.
REQ-025 Each item therefore SHALL take at least 2 cycles (SELECT plus EMIT); dispense_valid SHALL drop for at least one cycle between items.
REQ-026 EMIT: a wait counter SHALL reset on entry; after ACK_TIMEOUT cycles without ack, error=1000, dispense_valid drops, go to FINISH, remaining unchanged.
REQ-027 dispense_ack outside EMIT SHALL be ignored.
REQ-028 FINISH: done=1 for exactly one cycle, then go to IDLE.
REQ-029 Internal stock copies SHALL never underflow; external stock inputs are not read after start.
REQ-030 Arithmetic SHALL be unsigned 16-bit.

Reset
REQ-031 reset==0 SHALL give: state IDLE, dispense_valid=0, dispense_type=0000, busy=0, done=0, error=0000, remaining=0, internal stocks=0, wait counter=0.
REQ-032 Reset during EMIT SHALL drop dispense_valid asynchronously, with no done pulse and no further items.
REQ-033 After reset deasserts, the first start SHALL be accepted no earlier than the next rising edge.

Verification
REQ-034 credit=5000, price=1500, all stocks=10, ack every cycle valid is high -> items 2000,1000,500; remaining 3500->1500->500->0; error=0000; done pulse.
REQ-035 credit=5000, price=1000, num_2000=0, num_1000=1, num_500=10 -> items 1000,500x6; error=0000.
REQ-036 credit=1000, price=1500 -> no dispense_valid; error=0001; done one cycle after CHECK. Separately, credit=1200, price=500 -> error=0010.
REQ-037 credit=2000, price=1500, num_500=0 -> no items; error=0100; remaining=500.
REQ-038 ACK_TIMEOUT=4, ack never asserted -> dispense_valid high 4 cycles, then error=1000; done pulse; start asserted during busy ignored.
REQ-039 reset pulled low mid-EMIT after one acked item -> all outputs at REQ-031 values immediately; next start runs a fresh transaction.
